// File: rtl/rotary_input_filter_if.sv
// Encoder pin and conditioned-output bundle between the raw ROT_A/ROT_B pins,
// rotary_input_filter and the downstream rotary_shaft decoder.
interface rotary_input_filter_if;
   logic       ROT_A;
   logic       ROT_B;
   logic       rot_a_clean;
   logic       rot_b_clean;
   logic       rot_a_change;
   logic       rot_b_change;
   logic       ready;
   logic [7:0] glitch_count;

   modport master (
      output ROT_A, ROT_B,
      input  rot_a_clean, rot_b_clean, rot_a_change, rot_b_change, ready, glitch_count
   );

   modport slave (
      input  ROT_A, ROT_B,
      output rot_a_clean, rot_b_clean, rot_a_change, rot_b_change, ready, glitch_count
   );
endinterface

// File: rtl/rotary_input_filter.sv
// Two-flop synchroniser plus per-channel stability-counter debouncer for the
// rotary encoder pins, with change strobes, a ready flag and a saturating glitch count.
module rotary_input_filter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   rotary_input_filter_if.slave bus
);
   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           r_state;
   logic [1:0]       r_fill;
   logic [1:0]       r_s1;
   logic [1:0]       r_s2;
   logic [1:0]       r_clean;
   logic [1:0]       r_change;
   logic [CNT_W-1:0] r_cnt [2];
   logic             r_ready;
   logic [7:0]       r_glitch;

   logic [1:0]       w_abort;
   logic [8:0]       w_glitch_sum;
   logic [7:0]       w_glitch_next;

   // Abort detection and saturating glitch-count next value
   always_comb begin
      w_abort = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if ((r_state == ST_RUN) && (r_s2[i] == r_clean[i]) && (r_cnt[i] != {CNT_W{1'b0}})) begin
            w_abort[i] = 1'b1;
         end else begin
            w_abort[i] = 1'b0;
         end
      end
      w_glitch_sum = {1'b0, r_glitch} + 9'(w_abort[0]) + 9'(w_abort[1]);
      if (w_glitch_sum > 9'd255) begin
         w_glitch_next = 8'd255;
      end else begin
         w_glitch_next = w_glitch_sum[7:0];
      end
   end

   // Two-flop synchroniser; bit 0 is channel A, bit 1 is channel B
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 2'b00;
         r_s2 <= 2'b00;
      end else begin
         r_s1 <= {bus.ROT_B, bus.ROT_A};
         r_s2 <= r_s1;
      end
   end

   // INIT/RUN control and per-channel debounce
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_INIT;
         r_fill   <= 2'd0;
         r_clean  <= 2'b00;
         r_change <= 2'b00;
         r_ready  <= 1'b0;
         r_glitch <= 8'd0;
         for (int i = 0; i < 2; i++) begin
            r_cnt[i] <= {CNT_W{1'b0}};
         end
      end else begin
         case (r_state)
            ST_INIT: begin
               r_change <= 2'b00;
               // Third edge after release: s2 now carries a real pin sample
               if (r_fill == 2'd2) begin
                  r_clean <= r_s2;
                  r_ready <= 1'b1;
                  r_fill  <= 2'd0;
                  r_state <= ST_RUN;
               end else begin
                  r_fill <= r_fill + 2'd1;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < 2; i++) begin
                  if ((r_s2[i] != r_clean[i]) && (r_cnt[i] == CNT_LAST)) begin
                     r_clean[i]  <= r_s2[i];
                     r_cnt[i]    <= {CNT_W{1'b0}};
                     r_change[i] <= 1'b1;
                  end else if (r_s2[i] != r_clean[i]) begin
                     r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
                     r_change[i] <= 1'b0;
                  end else begin
                     r_cnt[i]    <= {CNT_W{1'b0}};
                     r_change[i] <= 1'b0;
                  end
               end
               r_glitch <= w_glitch_next;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign bus.rot_a_clean  = r_clean[0];
   assign bus.rot_b_clean  = r_clean[1];
   assign bus.rot_a_change = r_change[0];
   assign bus.rot_b_change = r_change[1];
   assign bus.ready        = r_ready;
   assign bus.glitch_count = r_glitch;
endmodule

// File: tb/tb_rotary_input_filter.sv
// Directed bench for rotary_input_filter with DEBOUNCE_CYCLES=4; pins are driven
// and outputs sampled on the falling edge, so the next rising edge is "edge k".
module tb_rotary_input_filter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;
   int   pulse_a = 0;
   int   pulse_b = 0;
   int   pa0;
   int   pb0;

   rotary_input_filter_if bus ();

   rotary_input_filter #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Count change strobes shortly after each rising edge
   always @(posedge clk) begin
      #1;
      if (bus.rot_a_change === 1'b1) pulse_a = pulse_a + 1;
      if (bus.rot_b_change === 1'b1) pulse_b = pulse_b + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: capture during reset, release, ready on third edge
      bus.ROT_A = 1'b1;
      bus.ROT_B = 1'b0;
      step(3);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_clean_a", 32'(bus.rot_a_clean), 32'd0);
      check("rst_glitch", 32'(bus.glitch_count), 32'd0);
      rst = 1'b0;
      step(2);
      check("init_ready_e2", 32'(bus.ready), 32'd0);
      check("init_clean_a_e2", 32'(bus.rot_a_clean), 32'd0);
      step(1);
      check("init_ready_e3", 32'(bus.ready), 32'd1);
      check("init_clean_a_e3", 32'(bus.rot_a_clean), 32'd1);
      check("init_clean_b_e3", 32'(bus.rot_b_clean), 32'd0);
      check("init_change_a", 32'(bus.rot_a_change), 32'd0);
      check("init_glitch", 32'(bus.glitch_count), 32'd0);
      check("init_pulses", 32'(pulse_a + pulse_b), 32'd0);

      // Bring A low so a 0->1 transition can be timed
      bus.ROT_A = 1'b0;
      step(10);
      check("a_low_settled", 32'(bus.rot_a_clean), 32'd0);
      check("a_low_pulse", 32'(pulse_a), 32'd1);

      // 2: 0->1 latency, clean and strobe at k+5, strobe gone at k+6
      bus.ROT_A = 1'b1;
      step(5);
      check("lat_clean_k4", 32'(bus.rot_a_clean), 32'd0);
      step(1);
      check("lat_clean_k5", 32'(bus.rot_a_clean), 32'd1);
      check("lat_change_k5", 32'(bus.rot_a_change), 32'd1);
      step(1);
      check("lat_change_k6", 32'(bus.rot_a_change), 32'd0);
      check("lat_glitch", 32'(bus.glitch_count), 32'd0);

      // 3: A high for three synchronised cycles only
      bus.ROT_A = 1'b0;
      step(10);
      pa0 = pulse_a;
      bus.ROT_A = 1'b1;
      step(3);
      bus.ROT_A = 1'b0;
      step(8);
      check("glitch_clean_a", 32'(bus.rot_a_clean), 32'd0);
      check("glitch_no_pulse", 32'(pulse_a - pa0), 32'd0);
      check("glitch_count_1", 32'(bus.glitch_count), 32'd1);

      // 4: both channels toggle together
      bus.ROT_A = 1'b1;
      bus.ROT_B = 1'b1;
      step(6);
      check("both_clean_a", 32'(bus.rot_a_clean), 32'd1);
      check("both_clean_b", 32'(bus.rot_b_clean), 32'd1);
      check("both_change_a", 32'(bus.rot_a_change), 32'd1);
      check("both_change_b", 32'(bus.rot_b_change), 32'd1);
      step(1);
      check("both_change_off", 32'({bus.rot_a_change, bus.rot_b_change}), 32'd0);

      // Single-channel glitch brings the count to an even value
      bus.ROT_A = 1'b0;
      step(2);
      bus.ROT_A = 1'b1;
      step(3);
      check("glitch_count_2", 32'(bus.glitch_count), 32'd2);

      // 5: 300 two-cycle dips on both channels, count saturates
      pa0 = pulse_a;
      pb0 = pulse_b;
      for (int n = 1; n <= 300; n++) begin
         bus.ROT_A = 1'b0;
         bus.ROT_B = 1'b0;
         step(2);
         bus.ROT_A = 1'b1;
         bus.ROT_B = 1'b1;
         step(3);
         if (n == 126) check("sat_254", 32'(bus.glitch_count), 32'd254);
         if (n == 127) check("sat_255", 32'(bus.glitch_count), 32'd255);
      end
      step(4);
      check("sat_final", 32'(bus.glitch_count), 32'd255);
      check("sat_clean_a", 32'(bus.rot_a_clean), 32'd1);
      check("sat_clean_b", 32'(bus.rot_b_clean), 32'd1);
      check("sat_no_pulses", 32'((pulse_a - pa0) + (pulse_b - pb0)), 32'd0);

      // 6: reset mid-transition (cnt_a=2 after edge k+3)
      bus.ROT_A = 1'b0;
      step(4);
      rst = 1'b1;
      #1;
      check("mid_rst_clean", 32'({bus.rot_a_clean, bus.rot_b_clean}), 32'd0);
      check("mid_rst_ready", 32'(bus.ready), 32'd0);
      check("mid_rst_glitch", 32'(bus.glitch_count), 32'd0);
      check("mid_rst_change", 32'({bus.rot_a_change, bus.rot_b_change}), 32'd0);
      bus.ROT_B = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);
      check("reinit_ready_e2", 32'(bus.ready), 32'd0);
      step(1);
      check("reinit_ready_e3", 32'(bus.ready), 32'd1);
      check("reinit_clean_a", 32'(bus.rot_a_clean), 32'd0);
      check("reinit_clean_b", 32'(bus.rot_b_clean), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
